branch_prediction_unit: RTL and testbench
=========================================

// Module: branch_prediction_unit
// PURPOSE
//  Fetch-stage branch predictor and decode-stage resolver for the 5-stage core. Predicts next PC from a
//  direct-mapped BTB with 2-bit saturating counters, carries the prediction into decode, and compares it
//  with branch_decision/branch_target from branch_decision_unit. Raises mispredict + redirect_pc (IF flush)
//  and trains the tables.
// PARAMETERS
//  BTB_ENTRIES  64  number of BTB/BHT entries, power of 2; index = pc[IDX_W+1:2], IDX_W = $clog2(BTB_ENTRIES)
//  TAG_W        8   tag bits taken from pc[IDX_W+2+TAG_W-1:IDX_W+2]
// PORTS
//  clk              in   1    core clock
//  reset_n          in   1    asynchronous active-low reset
//  if_pc            in   32   PC of instruction being fetched
//  if_valid         in   1    fetch slot holds a real instruction
//  stall            in   1    hazard stall: hold IF/ID prediction register
//  pred_taken       out  1    fetch-stage prediction: next PC = pred_target
//  pred_target      out  32   predicted target (0 when no BTB hit)
//  branch_type      in   BranchControl  decode-stage control (package_project_typedefs)
//  branch_decision  in   1    actual outcome from branch_decision_unit
//  branch_target    in   32   actual target from branch_decision_unit
//  mispredict       out  1    decode prediction wrong: flush IF, load redirect_pc
//  redirect_pc      out  32   branch_target if branch_decision else id_pc+4
// BEHAVIOUR
//  - Entry: valid, tag[TAG_W], target[32], ctr[2]. Reset: all valid=0, ctr=WNT(01), id regs=0.
//  - Fetch (comb): hit = valid[idx] && tag match && if_valid; pred_taken = hit && ctr[1];
//    pred_target = hit ? target : 0. Reset values: pred_taken=0, pred_target=0.
//  - IF/ID register (id_valid, id_pc, id_pred_taken, id_pred_target): loads on every rising edge when !stall;
//    holds when stall; id_valid loads 0 when mispredict (squash wrong-path fetch). Latency fetch->check = 1 cycle.
//  - is_branch = id_valid && branch_type in {BRANCH_EQ..BRANCH_GEU, JUMP_AL, JUMP_ALR}.
//  - mispredict (comb) = id_valid && !stall && ( (is_branch ? branch_decision : 0) != id_pred_taken
//    || (id_pred_taken && branch_target != id_pred_target) ). Non-branch predicted taken -> mispredict,
//    redirect_pc = id_pc+4. Reset: mispredict=0.
//  - redirect_pc arithmetic: 32-bit modulo; id_pc+4 wraps 0xFFFF_FFFC -> 0x0000_0000.
//  - Training on edge when is_branch && !stall: index/tag from id_pc. Taken: valid=1, tag, target=branch_target,
//    ctr sat-inc (11 holds). Not taken: ctr sat-dec (00 holds); valid/target unchanged; allocate nothing on miss.
//    Tag mismatch on taken branch: replace entry, ctr=WT(10). Non-branch predicted taken: clear valid.
//  - Same-cycle fetch read and training write to same index: fetch sees old contents (write-after-read).
//  - stall: no training, no mispredict, tables and id regs frozen.
//  - reset_n asserted mid-operation: all state cleared immediately, outputs to reset values asynchronously.
// CONFIGURATION
//  BPU_STATS_EN defined: adds outputs stat_branches[31:0], stat_mispredicts[31:0]; increment on each trained
//  branch / each asserted mispredict (not during stall); wrap at 2^32; reset 0. Undefined: ports and counters absent,
//  behaviour otherwise identical.
// STRUCTURE
//  - package_project_typedefs: BranchControl (existing), add typedef BtbEntry struct, localparams
//    CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
//  - One sub-module: btb_table (storage, async read port, sync write port, async clear).
// TESTING
//  1 Reset -> pred_taken=0, pred_target=0, mispredict=0 for any if_pc.
//  2 BEQ at 0x100 taken to 0x140, cold -> mispredict=1, redirect_pc=0x140; next fetch 0x100 -> pred_taken=1,
//    pred_target=0x140 (ctr 10).
//  3 Same BEQ then not-taken twice -> 1st: mispredict, redirect 0x104, ctr 01; next fetch pred_taken=0; 2nd: ctr 00.
//  4 Hit predicted taken, JALR resolves taken to 0x200 vs predicted 0x140 -> mispredict=1, redirect 0x200, target updated.
//  5 stall=1 with wrong prediction in ID -> mispredict=0, tables unchanged; stall=0 next cycle -> mispredict=1.
//  6 Aliasing: 0x100 trained, fetch 0x100+4*BTB_ENTRIES (different tag) -> pred_taken=0; with BPU_STATS_EN check counters.

Source files
------------

// File: rtl/branch_prediction_unit_pkg.sv
// Shared core typedefs: branch control encoding, BTB entry layout, 2-bit counter states and helpers.
package package_project_typedefs;

   typedef enum logic [3:0] {
      BRANCH_NONE = 4'd0,
      BRANCH_EQ   = 4'd1,
      BRANCH_NE   = 4'd2,
      BRANCH_LT   = 4'd3,
      BRANCH_GE   = 4'd4,
      BRANCH_LTU  = 4'd5,
      BRANCH_GEU  = 4'd6,
      JUMP_AL     = 4'd7,
      JUMP_ALR    = 4'd8
   } BranchControl;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Tag field sized for the widest legal TAG_W; unused upper bits stay zero.
   localparam int BTB_TAG_MAX = 32;

   typedef struct packed {
      logic                   valid;
      logic [BTB_TAG_MAX-1:0] tag;
      logic [31:0]            target;
      logic [1:0]             ctr;
   } BtbEntry;

   function automatic logic [BTB_TAG_MAX-1:0] btb_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
      logic [31:0] mask;
      mask = (tag_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << tag_w) - 32'h1);
      return (pc >> (idx_w + 2)) & mask;
   endfunction

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == CTR_ST) ? CTR_ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
   endfunction

   function automatic logic is_branch_ctl(input BranchControl bc);
      case (bc)
         BRANCH_EQ, BRANCH_NE, BRANCH_LT, BRANCH_GE,
         BRANCH_LTU, BRANCH_GEU, JUMP_AL, JUMP_ALR: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/branch_prediction_unit_btb_table.sv
// Direct-mapped BTB/BHT storage: two async read ports (fetch, decode), one sync write port, async clear.
module btb_table
   import package_project_typedefs::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6
)(
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [IDX_W-1:0] i_rd0_idx,
   output BtbEntry          o_rd0_entry,
   input  logic [IDX_W-1:0] i_rd1_idx,
   output BtbEntry          o_rd1_entry,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  BtbEntry          i_wr_entry
);

   localparam BtbEntry ENTRY_RESET = '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_WNT};

   BtbEntry r_mem [ENTRIES];

   // Entry storage; reads below see pre-edge contents, so same-index write is read-before-write.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_mem[i] <= ENTRY_RESET;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_entry;
      end
   end

   assign o_rd0_entry = r_mem[i_rd0_idx];
   assign o_rd1_entry = r_mem[i_rd1_idx];

endmodule

// File: rtl/branch_prediction_unit.sv
// Fetch-stage BTB predictor with decode-stage resolve/train and IF flush redirect.
// Optional `BPU_STATS_EN adds stat_branches / stat_mispredicts counters.
module branch_prediction_unit
   import package_project_typedefs::*;
#(
   parameter int BTB_ENTRIES = 64,
   parameter int TAG_W       = 8
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  if_pc,
   input  logic         if_valid,
   input  logic         stall,
   output logic         pred_taken,
   output logic [31:0]  pred_target,
   input  BranchControl branch_type,
   input  logic         branch_decision,
   input  logic [31:0]  branch_target,
   output logic         mispredict,
   output logic [31:0]  redirect_pc
`ifdef BPU_STATS_EN
   ,
   output logic [31:0]  stat_branches,
   output logic [31:0]  stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);

   logic [IDX_W-1:0]       w_if_idx;
   logic [IDX_W-1:0]       w_id_idx;
   logic [BTB_TAG_MAX-1:0] w_if_tag;
   logic [BTB_TAG_MAX-1:0] w_id_tag;
   BtbEntry                w_if_entry;
   BtbEntry                w_id_entry;
   logic                   w_if_hit;
   logic                   w_id_hit;
   logic                   w_is_branch;
   logic                   w_actual_taken;
   logic [31:0]            w_id_pc_plus4;
   logic                   w_wr_en;
   BtbEntry                w_wr_entry;

   logic        r_id_valid;
   logic [31:0] r_id_pc;
   logic        r_id_pred_taken;
   logic [31:0] r_id_pred_target;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_id_idx = r_id_pc[IDX_W+1:2];
   assign w_if_tag = btb_tag(if_pc, IDX_W, TAG_W);
   assign w_id_tag = btb_tag(r_id_pc, IDX_W, TAG_W);

   btb_table #(
      .ENTRIES (BTB_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_btb (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_rd0_idx   (w_if_idx),
      .o_rd0_entry (w_if_entry),
      .i_rd1_idx   (w_id_idx),
      .o_rd1_entry (w_id_entry),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (w_id_idx),
      .i_wr_entry  (w_wr_entry)
   );

   assign w_if_hit    = w_if_entry.valid && (w_if_entry.tag == w_if_tag) && if_valid;
   assign pred_taken  = w_if_hit && w_if_entry.ctr[1];
   assign pred_target = w_if_hit ? w_if_entry.target : 32'h0;

   assign w_is_branch    = r_id_valid && is_branch_ctl(branch_type);
   assign w_actual_taken = w_is_branch ? branch_decision : 1'b0;
   assign w_id_pc_plus4  = r_id_pc + 32'd4;
   assign w_id_hit       = w_id_entry.valid && (w_id_entry.tag == w_id_tag);

   assign mispredict  = r_id_valid && !stall &&
                        ((w_actual_taken != r_id_pred_taken) ||
                         (r_id_pred_taken && (branch_target != r_id_pred_target)));
   assign redirect_pc = w_actual_taken ? branch_target : w_id_pc_plus4;

   // Table update from the decode-stage outcome; not-taken misses allocate nothing.
   always_comb begin
      w_wr_en    = 1'b0;
      w_wr_entry = w_id_entry;
      if (stall) begin
         w_wr_en = 1'b0;
      end else if (w_is_branch) begin
         if (branch_decision) begin
            w_wr_en           = 1'b1;
            w_wr_entry.target = branch_target;
            if (w_id_hit) begin
               w_wr_entry.ctr = ctr_inc(w_id_entry.ctr);
            end else begin
               w_wr_entry.valid = 1'b1;
               w_wr_entry.tag   = w_id_tag;
               w_wr_entry.ctr   = CTR_WT;
            end
         end else if (w_id_hit) begin
            w_wr_en        = 1'b1;
            w_wr_entry.ctr = ctr_dec(w_id_entry.ctr);
         end else begin
            w_wr_en = 1'b0;
         end
      end else if (r_id_valid && r_id_pred_taken) begin
         w_wr_en          = 1'b1;
         w_wr_entry.valid = 1'b0;
      end else begin
         w_wr_en = 1'b0;
      end
   end

   // IF/ID prediction register; a mispredict squashes the wrong-path fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_id_valid       <= 1'b0;
         r_id_pc          <= 32'h0;
         r_id_pred_taken  <= 1'b0;
         r_id_pred_target <= 32'h0;
      end else if (!stall) begin
         r_id_valid       <= if_valid && !mispredict;
         r_id_pc          <= if_pc;
         r_id_pred_taken  <= pred_taken;
         r_id_pred_target <= pred_target;
      end
   end

`ifdef BPU_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stat_branches    <= 32'h0;
         r_stat_mispredicts <= 32'h0;
      end else begin
         if (w_is_branch && !stall) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Table-driven scoreboard bench for branch_prediction_unit (default 64 entries, 8-bit tags).
module tb_branch_prediction_unit;
   import package_project_typedefs::*;

   typedef struct {
      logic [31:0]  pc;
      logic         iv;
      logic         st;
      BranchControl bt;
      logic         bd;
      logic [31:0]  btgt;
      logic         e_pt;
      logic [31:0]  e_ptgt;
      logic         e_mis;
      logic [31:0]  e_rd;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [31:0]  if_pc;
   logic         if_valid;
   logic         stall;
   logic         pred_taken;
   logic [31:0]  pred_target;
   BranchControl branch_type;
   logic         branch_decision;
   logic [31:0]  branch_target;
   logic         mispredict;
   logic [31:0]  redirect_pc;
`ifdef BPU_STATS_EN
   logic [31:0]  stat_branches;
   logic [31:0]  stat_mispredicts;
`endif

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];
   logic m_id_valid;
   int unsigned exp_br;
   int unsigned exp_mis;

   branch_prediction_unit dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .if_pc           (if_pc),
      .if_valid        (if_valid),
      .stall           (stall),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .branch_type     (branch_type),
      .branch_decision (branch_decision),
      .branch_target   (branch_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc)
`ifdef BPU_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] pc, input logic iv, input logic st, input BranchControl bt,
                               input logic bd, input logic [31:0] btgt, input logic e_pt, input logic [31:0] e_ptgt,
                               input logic e_mis, input logic [31:0] e_rd);
      vec_t v;
      v.pc = pc; v.iv = iv; v.st = st; v.bt = bt; v.bd = bd; v.btgt = btgt;
      v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mis = e_mis; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask

   // One cycle: drive at negedge, compare mid-low-phase, then the next posedge commits.
   task automatic apply(input vec_t r, input string tag);
      vec_t e;
      @(negedge clk);
      if_pc = r.pc; if_valid = r.iv; stall = r.st;
      branch_type = r.bt; branch_decision = r.bd; branch_target = r.btgt;
      exp_q.push_back(r);
      #2;
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " pred_taken"}, 32'(pred_taken), 32'(e.e_pt));
         chk({tag, " pred_target"}, pred_target, e.e_ptgt);
         chk({tag, " mispredict"}, 32'(mispredict), 32'(e.e_mis));
         if (e.e_mis) chk({tag, " redirect_pc"}, redirect_pc, e.e_rd);
         if (m_id_valid && !e.st && (e.bt inside {BRANCH_EQ, BRANCH_NE, BRANCH_LT, BRANCH_GE,
                                                  BRANCH_LTU, BRANCH_GEU, JUMP_AL, JUMP_ALR}))
            exp_br++;
         if (e.e_mis) exp_mis++;
         if (!e.st) m_id_valid = e.iv && !e.e_mis;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rst_pcs [4];
      rst_pcs[0] = 32'h0000_0100; rst_pcs[1] = 32'h0000_0200;
      rst_pcs[2] = 32'hFFFF_FFFC; rst_pcs[3] = 32'h0000_0000;

      // pc, iv, stall, type, decision, target | pred_taken, pred_target, mispredict, redirect
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   1, 32'h140, 0, 32'h0,   1, 32'h140));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   1, 32'h140, 0, 32'h0));
      vecs.push_back(mk(32'h140, 1, 0, BRANCH_EQ,   0, 32'h140, 0, 32'h0,   1, 32'h104));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h140, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   0, 32'h140, 0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h108, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h140, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   1, 32'h140, 0, 32'h0,   1, 32'h140));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h140, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   1, 32'h140, 0, 32'h0,   1, 32'h140));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   1, 32'h140, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, JUMP_ALR,    1, 32'h200, 0, 32'h0,   1, 32'h200));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   1, 32'h200, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, JUMP_ALR,    1, 32'h200, 0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   1, 32'h200, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   1, 32'h104));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h200, 1, 0, BRANCH_NE,   1, 32'h280, 0, 32'h0,   1, 32'h280));
      vecs.push_back(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0,   1, 32'h280, 0, 32'h0));
      vecs.push_back(mk(32'h100, 1, 0, BRANCH_NE,   1, 32'h280, 0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h200, 0, 0, BRANCH_NONE, 0, 32'h0,   0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   1, 32'h140, 0, 32'h0,   0, 32'h0));
      vecs.push_back(mk(32'hFFFF_FFFC, 1, 0, BRANCH_NONE, 0, 32'h0, 0, 32'h0, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   1, 32'h10,  0, 32'h0,   1, 32'h10));
      vecs.push_back(mk(32'hFFFF_FFFC, 1, 0, BRANCH_NONE, 0, 32'h0, 1, 32'h10, 0, 32'h0));
      vecs.push_back(mk(32'h104, 1, 0, BRANCH_EQ,   0, 32'h0,   0, 32'h0,   1, 32'h0));
      vecs.push_back(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0,   1, 32'h280, 0, 32'h0));

      reset_n = 1'b0; stall = 1'b0; if_valid = 1'b1;
      branch_type = BRANCH_EQ; branch_decision = 1'b1; branch_target = 32'h140;
      m_id_valid = 1'b0; exp_br = 0; exp_mis = 0;
      for (int i = 0; i < 4; i++) begin
         if_pc = rst_pcs[i];
         #2;
         chk($sformatf("reset%0d pred_taken", i), 32'(pred_taken), 32'd0);
         chk($sformatf("reset%0d pred_target", i), pred_target, 32'h0);
         chk($sformatf("reset%0d mispredict", i), 32'(mispredict), 32'd0);
      end
      if_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("row%0d", i));
      end

      // Stall holds a wrong prediction in ID for two edges; release must then flag it.
      apply(mk(32'h104, 1, 1, BRANCH_EQ,   0, 32'h0, 0, 32'h0,   0, 32'h0),   "stallA");
      apply(mk(32'h200, 1, 1, BRANCH_EQ,   0, 32'h0, 1, 32'h280, 0, 32'h0),   "stallB");
      apply(mk(32'h200, 1, 0, BRANCH_EQ,   0, 32'h0, 1, 32'h280, 1, 32'h204), "stallC");
      apply(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0, 1, 32'h280, 0, 32'h0),   "stallD");
`ifdef BPU_STATS_EN
      chk("stat_branches", stat_branches, exp_br);
      chk("stat_mispredicts", stat_mispredicts, exp_mis);
`endif

      // Asynchronous reset in the middle of a mispredicting cycle.
      apply(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0, 1, 32'h280, 1, 32'h204), "preRst");
      #1 reset_n = 1'b0;
      #1;
      chk("midrst pred_taken", 32'(pred_taken), 32'd0);
      chk("midrst pred_target", pred_target, 32'h0);
      chk("midrst mispredict", 32'(mispredict), 32'd0);
`ifdef BPU_STATS_EN
      chk("midrst stat_branches", stat_branches, 32'h0);
      chk("midrst stat_mispredicts", stat_mispredicts, 32'h0);
`endif
      if_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_id_valid = 1'b0; exp_br = 0; exp_mis = 0;
      apply(mk(32'h200, 1, 0, BRANCH_NONE, 0, 32'h0, 0, 32'h0, 0, 32'h0), "postRst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
